// File: rtl/dp_ram_pkg.sv
// Shared types and helpers for the byte-enable dual-port RAM.
package dp_ram_pkg;

   localparam int unsigned MAX_WIDTH = 1024;
   localparam int unsigned MAX_BYTES = MAX_WIDTH / 8;

   typedef enum int unsigned {
      READ_FIRST  = 0,
      WRITE_FIRST = 1
   } rdw_mode_e;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } clr_state_e;

   // Replace the bytes of old_word selected by be with those of new_word.
   function automatic logic [MAX_WIDTH-1:0] byte_merge(
      input logic [MAX_WIDTH-1:0] old_word,
      input logic [MAX_WIDTH-1:0] new_word,
      input logic [MAX_BYTES-1:0] be
   );
      logic [MAX_WIDTH-1:0] merged;
      merged = old_word;
      for (int unsigned i = 0; i < MAX_BYTES; i++) begin
         if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/dp_ram_rd_pipe.sv
// Read data / valid output registers, one or two stages deep.
module dp_ram_rd_pipe #(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] rd,
   output logic             rvalid
);

   logic             v1;
   logic [WIDTH-1:0] d1;

   // Data only advances with a valid access so rd holds otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0;
         d1 <= '0;
      end else begin
         v1 <= valid;
         if (valid) d1 <= data;
      end
   end

   if (READ_LATENCY >= 2) begin : g_lat2
      logic             v2;
      logic [WIDTH-1:0] d2;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v2 <= 1'b0;
            d2 <= '0;
         end else begin
            v2 <= v1;
            if (v1) d2 <= d1;
         end
      end

      assign rd     = d2;
      assign rvalid = v2;
   end else begin : g_lat1
      assign rd     = d1;
      assign rvalid = v1;
   end

endmodule

// File: rtl/dp_ram_be.sv
// True dual-port RAM with byte enables, read-during-write mode and a clear engine.
module dp_ram_be
   import dp_ram_pkg::*;
#(
   parameter int unsigned      DEPTH        = 16,
   parameter int unsigned      WIDTH        = 32,
   parameter int unsigned      READ_LATENCY = 1,
   parameter int unsigned      RDW_MODE     = 0,
   parameter logic [WIDTH-1:0] INIT_VALUE   = '0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear_req,
   output logic                       ready,
   input  logic                       en_a,
   input  logic                       we_a,
   input  logic [WIDTH/8-1:0]         be_a,
   input  logic [$clog2(DEPTH)-1:0]   addr_a,
   input  logic [WIDTH-1:0]           wd_a,
   output logic [WIDTH-1:0]           rd_a,
   output logic                       rvalid_a,
   input  logic                       en_b,
   input  logic                       we_b,
   input  logic [WIDTH/8-1:0]         be_b,
   input  logic [$clog2(DEPTH)-1:0]   addr_b,
   input  logic [WIDTH-1:0]           wd_b,
   output logic [WIDTH-1:0]           rd_b,
   output logic                       rvalid_b,
   output logic                       collision
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];

   clr_state_e       state, state_next;
   logic [AW-1:0]    cnt, cnt_next;

   logic             acc_a, acc_b, ok_a, ok_b, wr_a, wr_b, same_addr;
   logic [WIDTH-1:0] old_a, old_b, own_a, own_b, word_a_new;
   logic [WIDTH-1:0] rdata_a, rdata_b;

   // Clear engine state register; ready tracks the next state so it is a flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= CLEAR;
         cnt       <= '0;
         ready     <= 1'b0;
         collision <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         ready     <= (state_next == IDLE);
         collision <= wr_a & wr_b & same_addr & (|(be_a & be_b));
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         CLEAR: begin
            cnt_next = cnt + AW'(1);
            if (cnt == AW'(DEPTH - 1)) begin
               state_next = IDLE;
               cnt_next   = '0;
            end
         end
         IDLE: begin
            if (clear_req) begin
               state_next = CLEAR;
               cnt_next   = '0;
            end
         end
         default: begin
            state_next = CLEAR;
            cnt_next   = '0;
         end
      endcase
   end

   assign acc_a     = ready & en_a;
   assign acc_b     = ready & en_b;
   assign ok_a      = 32'(addr_a) < DEPTH;
   assign ok_b      = 32'(addr_b) < DEPTH;
   assign wr_a      = acc_a & we_a & ok_a;
   assign wr_b      = acc_b & we_b & ok_b;
   assign same_addr = (addr_a == addr_b);

   assign old_a = ok_a ? mem[addr_a] : INIT_VALUE;
   assign old_b = ok_b ? mem[addr_b] : INIT_VALUE;
   assign own_a = WIDTH'(byte_merge(MAX_WIDTH'(old_a), MAX_WIDTH'(wd_a), MAX_BYTES'(be_a)));
   assign own_b = WIDTH'(byte_merge(MAX_WIDTH'(old_b), MAX_WIDTH'(wd_b), MAX_BYTES'(be_b)));

   // Same-address double write: B's bytes first, then A's bytes on top.
   assign word_a_new = (wr_b && same_addr)
      ? WIDTH'(byte_merge(MAX_WIDTH'(own_b), MAX_WIDTH'(wd_a), MAX_BYTES'(be_a)))
      : own_a;

   assign rdata_a = !ok_a ? INIT_VALUE
                  : (RDW_MODE == WRITE_FIRST && we_a) ? own_a : old_a;
   assign rdata_b = !ok_b ? INIT_VALUE
                  : (RDW_MODE == WRITE_FIRST && we_b) ? own_b : old_b;

   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         mem[cnt] <= INIT_VALUE;
      end else begin
         if (wr_b && !(wr_a && same_addr)) mem[addr_b] <= own_b;
         if (wr_a)                         mem[addr_a] <= word_a_new;
      end
   end

   dp_ram_rd_pipe #(
      .WIDTH        (WIDTH),
      .READ_LATENCY (READ_LATENCY)
   ) u_pipe_a (
      .clk    (clk),
      .rst_n  (rst_n),
      .valid  (acc_a),
      .data   (rdata_a),
      .rd     (rd_a),
      .rvalid (rvalid_a)
   );

   dp_ram_rd_pipe #(
      .WIDTH        (WIDTH),
      .READ_LATENCY (READ_LATENCY)
   ) u_pipe_b (
      .clk    (clk),
      .rst_n  (rst_n),
      .valid  (acc_b),
      .data   (rdata_b),
      .rd     (rd_b),
      .rvalid (rvalid_b)
   );

endmodule

// File: tb/tb_dp_ram_be.sv
// Scoreboard bench for dp_ram_be: two configurations share one randomized stimulus stream.
module tb_dp_ram_be;

   typedef struct {
      bit          clr;
      bit          en   [2];
      bit          we   [2];
      logic [3:0]  be   [2];
      logic [3:0]  addr [2];
      logic [31:0] wd   [2];
   } stim_t;

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear_req = 1'b0;
   logic        en_a = 1'b0, we_a = 1'b0, en_b = 1'b0, we_b = 1'b0;
   logic [3:0]  be_a = '0, be_b = '0, addr_a = '0, addr_b = '0;
   logic [31:0] wd_a = '0, wd_b = '0;

   logic [31:0] rd_o  [4];
   logic        rv_o  [4];
   logic        rdy_o [2];
   logic        col_o [2];

   always #5 clk = ~clk;

   dp_ram_be #(
      .DEPTH(16), .WIDTH(32), .READ_LATENCY(1), .RDW_MODE(0), .INIT_VALUE(32'h0000_0000)
   ) u_dut0 (
      .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(rdy_o[0]),
      .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .wd_a(wd_a),
      .rd_a(rd_o[0]), .rvalid_a(rv_o[0]),
      .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .wd_b(wd_b),
      .rd_b(rd_o[1]), .rvalid_b(rv_o[1]),
      .collision(col_o[0])
   );

   dp_ram_be #(
      .DEPTH(12), .WIDTH(32), .READ_LATENCY(2), .RDW_MODE(1), .INIT_VALUE(32'hA5C3_0F1E)
   ) u_dut1 (
      .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(rdy_o[1]),
      .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .wd_a(wd_a),
      .rd_a(rd_o[2]), .rvalid_a(rv_o[2]),
      .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .wd_b(wd_b),
      .rd_b(rd_o[3]), .rvalid_b(rv_o[3]),
      .collision(col_o[1])
   );

   int          cfg_depth [2] = '{16, 12};
   int          cfg_lat   [2] = '{1, 2};
   int          cfg_rdw   [2] = '{0, 1};
   logic [31:0] cfg_init  [2] = '{32'h0000_0000, 32'hA5C3_0F1E};

   // Reference model: word array per instance, clear countdown, expected-read queues.
   logic [31:0] mm [2][16];
   bit          m_ready   [2];
   int          m_left    [2];
   bit          coll_next [2];
   bit          exp_ready [2];
   bit          exp_coll  [2];
   exp_t        sq [4][$];

   int cyc = 0;
   int n_chk = 0;
   int n_err = 0;
   bit rel = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
      return r;
   endfunction

   // Effect of the coming clock edge on each instance's model.
   function automatic void model_step(input stim_t s);
      logic [31:0] rdv;
      bit          inr [2];
      for (int d = 0; d < 2; d++) begin
         if (!m_ready[d]) begin
            coll_next[d] = 1'b0;
            m_left[d]--;
            if (m_left[d] == 0) begin
               m_ready[d] = 1'b1;
               for (int i = 0; i < 16; i++) mm[d][i] = cfg_init[d];
            end
         end else begin
            for (int p = 0; p < 2; p++) inr[p] = (int'(s.addr[p]) < cfg_depth[d]);
            for (int p = 0; p < 2; p++) begin
               if (s.en[p]) begin
                  if (!inr[p])                       rdv = cfg_init[d];
                  else if (s.we[p] && cfg_rdw[d] == 1) rdv = merge(mm[d][s.addr[p]], s.wd[p], s.be[p]);
                  else                               rdv = mm[d][s.addr[p]];
                  sq[d*2+p].push_back('{data: rdv, due: cyc + cfg_lat[d]});
               end
            end
            coll_next[d] = s.en[0] && s.we[0] && s.en[1] && s.we[1] && inr[0] && inr[1]
                           && (s.addr[0] == s.addr[1]) && ((s.be[0] & s.be[1]) != 4'b0);
            // Port B applied first so port A's bytes win on overlap.
            for (int p = 1; p >= 0; p--)
               if (s.en[p] && s.we[p] && inr[p])
                  mm[d][s.addr[p]] = merge(mm[d][s.addr[p]], s.wd[p], s.be[p]);
            if (s.clr) begin
               m_ready[d] = 1'b0;
               m_left[d]  = cfg_depth[d];
            end
         end
      end
   endfunction

   function automatic void model_reset();
      for (int q = 0; q < 4; q++) sq[q].delete();
      for (int d = 0; d < 2; d++) begin
         m_ready[d]   = 1'b0;
         m_left[d]    = cfg_depth[d];
         coll_next[d] = 1'b0;
         exp_ready[d] = 1'b0;
         exp_coll[d]  = 1'b0;
      end
   endfunction

   function automatic stim_t idle_stim();
      stim_t s;
      s.clr = 1'b0;
      for (int p = 0; p < 2; p++) begin
         s.en[p] = 1'b0; s.we[p] = 1'b0; s.be[p] = '0; s.addr[p] = '0; s.wd[p] = '0;
      end
      return s;
   endfunction

   function automatic stim_t rand_stim();
      stim_t s;
      s.clr = ($urandom_range(0, 59) == 0);
      for (int p = 0; p < 2; p++) begin
         s.en[p]   = ($urandom_range(0, 3) != 0);
         s.we[p]   = 1'($urandom_range(0, 1));
         s.be[p]   = 4'($urandom);
         s.addr[p] = 4'($urandom);
         s.wd[p]   = $urandom;
      end
      if ($urandom_range(0, 3) == 0) s.addr[1] = s.addr[0];
      return s;
   endfunction

   task automatic cycle(input stim_t s);
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         exp_ready[d] = m_ready[d];
         exp_coll[d]  = coll_next[d];
      end
      if (rel) begin
         rst_n = 1'b1;
         rel   = 1'b0;
      end
      clear_req = s.clr;
      en_a = s.en[0]; we_a = s.we[0]; be_a = s.be[0]; addr_a = s.addr[0]; wd_a = s.wd[0];
      en_b = s.en[1]; we_b = s.we[1]; be_b = s.be[1]; addr_b = s.addr[1]; wd_b = s.wd[1];
      if (rst_n) model_step(s);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(idle_stim());
   endtask

   task automatic wr(input int p, input int a, input logic [31:0] d, input logic [3:0] be);
      stim_t s;
      s = idle_stim();
      s.en[p] = 1'b1; s.we[p] = 1'b1; s.addr[p] = 4'(a); s.wd[p] = d; s.be[p] = be;
      cycle(s);
   endtask

   task automatic rd(input int p, input int a);
      stim_t s;
      s = idle_stim();
      s.en[p] = 1'b1; s.addr[p] = 4'(a);
      cycle(s);
   endtask

   task automatic read_all();
      stim_t s;
      for (int i = 0; i < 16; i++) begin
         s = idle_stim();
         s.en[0] = 1'b1; s.addr[0] = 4'(i);
         s.en[1] = 1'b1; s.addr[1] = 4'(15 - i);
         cycle(s);
      end
   endtask

   task automatic rand_cycles(input int n);
      for (int i = 0; i < n; i++) cycle(rand_stim());
   endtask

   // Reset asserted between edges; outputs must clear without waiting for a clock.
   task automatic async_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      clear_req = 1'b0; en_a = 1'b0; en_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("reset_ready%0d", d), 32'(rdy_o[d]), 32'd0);
         chk($sformatf("reset_collision%0d", d), 32'(col_o[d]), 32'd0);
      end
      for (int q = 0; q < 4; q++) begin
         chk($sformatf("reset_rvalid%0d", q), 32'(rv_o[q]), 32'd0);
         chk($sformatf("reset_rd%0d", q), rd_o[q], 32'd0);
      end
      model_reset();
      idle(2);
      rel = 1'b1;
      idle(1);
   endtask

   // Monitor: ready/collision every cycle, rvalid timing and data from the queues.
   always @(negedge clk) begin
      bit   exp_v;
      exp_t e;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("ready%0d", d), 32'(rdy_o[d]), 32'(exp_ready[d]));
         chk($sformatf("collision%0d", d), 32'(col_o[d]), 32'(exp_coll[d]));
      end
      for (int q = 0; q < 4; q++) begin
         exp_v = (sq[q].size() > 0) && (sq[q][0].due == cyc);
         chk($sformatf("rvalid%0d", q), 32'(rv_o[q]), 32'(exp_v));
         if (exp_v) begin
            e = sq[q].pop_front();
            if (rv_o[q]) chk($sformatf("rd%0d", q), rd_o[q], e.data);
         end
      end
   end

   initial begin
      stim_t s;
      model_reset();
      idle(2);
      rel = 1'b1;
      idle(1);
      idle(20);
      read_all();

      wr(0, 3, 32'hDEAD_BEEF, 4'b0101);
      rd(0, 3);

      wr(0, 5, 32'h1111_1111, 4'hF);
      wr(0, 5, 32'h2222_2222, 4'hF);
      rd(0, 5);

      s = idle_stim();
      s.en   = '{1'b1, 1'b1};
      s.we   = '{1'b1, 1'b1};
      s.addr = '{4'd7, 4'd7};
      s.wd   = '{32'hAAAA_AAAA, 32'hBBBB_BBBB};
      s.be   = '{4'b0011, 4'b0110};
      cycle(s);
      idle(1);
      rd(0, 7);

      s = idle_stim();
      s.en = '{1'b1, 1'b1}; s.we[0] = 1'b1; s.be[0] = 4'hF;
      s.addr = '{4'd9, 4'd9}; s.wd[0] = 32'h5A5A_0909;
      cycle(s);
      rd(1, 9);

      rd(0, 0); rd(0, 1); rd(0, 2);
      idle(3);

      s = idle_stim();
      s.clr = 1'b1; s.en[0] = 1'b1; s.addr[0] = 4'd4;
      cycle(s);
      for (int i = 0; i < 20; i++) begin
         s = rand_stim();
         s.clr = 1'b0;
         cycle(s);
      end
      read_all();

      rand_cycles(400);
      idle(20);

      s = idle_stim();
      s.clr = 1'b1;
      cycle(s);
      idle(5);
      async_reset();
      idle(20);
      read_all();

      rand_cycles(30);
      async_reset();
      idle(20);
      rand_cycles(150);

      idle(6);
      for (int q = 0; q < 4; q++)
         chk($sformatf("drain%0d", q), 32'(sq[q].size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
